// File: rtl/design36_pkg.sv
// design36_pkg: shared definitions for the design36 registered adder.
//   DEFAULT_W        default operand/result width
//   design36_state_t handshake FSM state (IDLE: no result, DONE: result valid)
package design36_pkg;

    localparam int unsigned DEFAULT_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } design36_state_t;

endpackage

// File: rtl/design36_adder.sv
// design36_adder: purely combinational W-bit unsigned adder.
// Ports:
//   a     [W-1:0] operand A
//   b     [W-1:0] operand B
//   sum   [W-1:0] (a + b) mod 2^W
//   carry         bit W of the (W+1)-bit sum
module design36_adder
    import design36_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full_sum;

    // Zero-extend both operands so the carry lands in the top bit.
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b};
        sum      = full_sum[W-1:0];
        carry    = full_sum[W];
    end

endmodule

// File: rtl/design36.sv
// design36: single-cycle registered W-bit adder with a start/valid handshake.
// A start pulse samples a/b; one cycle later y holds (a+b) mod 2^W and valid is
// high for that cycle. No backpressure; a start every cycle is legal.
// Build option: define DESIGN36_CARRY_OUT_EN to add the registered carry output.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high (has priority over start)
//   start  operation request; operands sampled on the edge where start=1
//   a, b   [W-1:0] unsigned operands
//   y      [W-1:0] registered sum, holds between operations
//   carry  (DESIGN36_CARRY_OUT_EN only) registered bit W of a+b
//   valid  one-cycle pulse: y holds the result of the previous start
module design36
    import design36_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
`ifdef DESIGN36_CARRY_OUT_EN
    output logic         carry,
`endif
    output logic         valid
);

    design36_state_t state_q, state_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    adder_sum;

`ifdef DESIGN36_CARRY_OUT_EN
    logic            adder_carry;
    logic            carry_q, carry_d;
`else
    // Carry output of the adder is intentionally not consumed in this build.
    logic            adder_carry_unused;
`endif

    design36_adder #(
        .W (W)
    ) u_adder (
        .a     (a),
        .b     (b),
        .sum   (adder_sum),
`ifdef DESIGN36_CARRY_OUT_EN
        .carry (adder_carry)
`else
        .carry (adder_carry_unused)
`endif
    );

    // Next-state: valid follows start one cycle later; reset handled in the register.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? DONE : IDLE;
            DONE:    state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath enable: the mux keeps y untouched (and X-free) when start=0.
    always_comb begin
        y_d = y_q;
        if (start) begin
            y_d = adder_sum;
        end
    end

`ifdef DESIGN36_CARRY_OUT_EN
    always_comb begin
        carry_d = carry_q;
        if (start) begin
            carry_d = adder_carry;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

`ifdef DESIGN36_CARRY_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;
`endif

    assign y     = y_q;
    assign valid = (state_q == DONE);

endmodule

// File: tb/tb_design36.sv
// tb_design36: directed, table-driven self-checking bench for design36 (W=10).
module tb_design36;

    localparam int unsigned W = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         valid;
`ifdef DESIGN36_CARRY_OUT_EN
    logic         carry;
`endif

    int checks = 0;
    int errors = 0;

    design36 #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .y     (y),
`ifdef DESIGN36_CARRY_OUT_EN
        .carry (carry),
`endif
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rst;
        logic         start;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         exp_valid;
        logic [W-1:0] exp_y;
        logic         exp_carry;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic ev, input logic [W-1:0] ey,
                                 input logic ec);
        check({name, ".valid"}, {31'd0, valid}, {31'd0, ev});
        check({name, ".y"}, {22'd0, y}, {22'd0, ey});
`ifdef DESIGN36_CARRY_OUT_EN
        check({name, ".carry"}, {31'd0, carry}, {31'd0, ec});
`else
        if (ec === 1'bz) begin
            // carry expectation unused in this build
        end
`endif
    endtask

    // Drive one vector, advance one edge, then sample away from the edge.
    task automatic apply(input vec_t v);
        rst   = v.rst;
        start = v.start;
        a     = v.a;
        b     = v.b;
        @(posedge clk);
        #1;
        check_outputs(v.name, v.exp_valid, v.exp_y, v.exp_carry);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        a     = 10'd5;
        b     = 10'd7;

        //                name           rst   start a        b        valid y       carry
        vecs.push_back('{"reset0",       1'b1, 1'b1, 10'd5,   10'd7,   1'b0, 10'd0,   1'b0});
        vecs.push_back('{"reset1",       1'b1, 1'b1, 10'd5,   10'd7,   1'b0, 10'd0,   1'b0});
        vecs.push_back('{"reset2",       1'b1, 1'b1, 10'd5,   10'd7,   1'b0, 10'd0,   1'b0});
        vecs.push_back('{"post_reset",   1'b0, 1'b0, 10'd5,   10'd7,   1'b0, 10'd0,   1'b0});
        vecs.push_back('{"basic",        1'b0, 1'b1, 10'd3,   10'd5,   1'b1, 10'd8,   1'b0});
        vecs.push_back('{"basic_hold",   1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 10'd8,   1'b0});
        vecs.push_back('{"wrap",         1'b0, 1'b1, 10'd1023, 10'd1,  1'b1, 10'd0,   1'b1});
        vecs.push_back('{"wrap_hold",    1'b0, 1'b0, 10'd77,  10'd9,   1'b0, 10'd0,   1'b1});
        vecs.push_back('{"b2b_first",    1'b0, 1'b1, 10'd10,  10'd20,  1'b1, 10'd30,  1'b0});
        vecs.push_back('{"b2b_second",   1'b0, 1'b1, 10'd100, 10'd200, 1'b1, 10'd300, 1'b0});
        vecs.push_back('{"b2b_end",      1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 10'd300, 1'b0});
        vecs.push_back('{"mid_start",    1'b0, 1'b1, 10'd40,  10'd2,   1'b1, 10'd42,  1'b0});
        vecs.push_back('{"mid_rst",      1'b1, 1'b1, 10'd9,   10'd9,   1'b0, 10'd0,   1'b0});
        vecs.push_back('{"mid_after",    1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 10'd0,   1'b0});
        vecs.push_back('{"wrap_c",       1'b0, 1'b1, 10'd600, 10'd500, 1'b1, 10'd76,  1'b1});
        vecs.push_back('{"same_rst",     1'b1, 1'b1, 10'd40,  10'd2,   1'b0, 10'd0,   1'b0});
        vecs.push_back('{"same_after",   1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 10'd0,   1'b0});
        vecs.push_back('{"set_y",        1'b0, 1'b1, 10'd512, 10'd17,  1'b1, 10'd529, 1'b0});
        vecs.push_back('{"x_idle",       1'b0, 1'b0, 'x,      'x,      1'b0, 10'd529, 1'b0});
        vecs.push_back('{"x_idle2",      1'b0, 1'b0, 'x,      'x,      1'b0, 10'd529, 1'b0});

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // Random sweep: start pulses spaced 3 cycles apart; y holds, valid stays low.
        for (int n = 0; n < 10; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [W:0]   s;
            vec_t         v;
            ra = W'($urandom_range(1023, 0));
            rb = W'($urandom_range(1023, 0));
            s  = {1'b0, ra} + {1'b0, rb};
            v  = '{$sformatf("rand%0d", n), 1'b0, 1'b1, ra, rb, 1'b1, s[W-1:0], s[W]};
            apply(v);
            for (int k = 0; k < 2; k++) begin
                v = '{$sformatf("rand%0d_idle%0d", n, k), 1'b0, 1'b0, 'x, 'x, 1'b0,
                      s[W-1:0], s[W]};
                apply(v);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: the sequence above is bounded, this only guards against a stalled clock.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/design36.md
Name: design36

Overview:
- Single-cycle registered W-bit adder with a start/valid handshake.
- Upstream pulses `start` with operands on `a`/`b`; the block registers the modulo-2^W sum and raises `valid` for one cycle.
- Used as a small datapath leaf that is driven by a controller. There is no backpressure.

Parameters:
- W, 10, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  operation request; operands are sampled on the clock edge where start=1
- a  input  W  operand A, unsigned
- b  input  W  operand B, unsigned
- y  output  W  registered sum (a+b) mod 2^W
- valid  output  1  one-cycle pulse indicating y holds the result of the previous start

Behaviour:
- All state updates occur on the rising edge of clk. No asynchronous paths.
- Reset:
  - If rst=1 at an edge, then y<=0, valid<=0 and the FSM goes to IDLE (carry<=0 when the optional feature is enabled).
  - Reset has priority over start.
  - valid must read 0 on every edge where rst=1 is sampled, including the first edge after rst asserts.
- FSM states:
  - IDLE: valid=0.
  - DONE: valid=1.
- FSM transitions (rst=0):
  - IDLE, start=1 -> DONE.
  - IDLE, start=0 -> IDLE.
  - DONE, start=1 -> DONE. Back-to-back starts keep valid high; each cycle carries the new sum.
  - DONE, start=0 -> IDLE.
  - Equivalent to valid <= start when rst=0.
- Latency: exactly 1 cycle. start sampled at edge N gives valid=1 and y=sum after edge N+1's update, i.e. visible during cycle N+1.
- Datapath:
  - On an edge with start=1 and rst=0: y <= a + b, truncated to W bits. Wrap-around is silent.
  - On an edge with start=0: y holds its previous value. y is not cleared when valid drops.
- Operands are don't-care when start=0. X on a/b while start=0 must not propagate into y.
- Reset mid-operation: rst asserted in the cycle valid would rise forces valid=0 and y=0. Any start sampled together with rst is discarded.
- start is ignored while rst=1. The first start honoured is the one on the first edge with rst=0.
- No internal buffering. A start every cycle is legal and sustains full throughput.

Optional Feature:
- Macro: DESIGN36_CARRY_OUT_EN.
- Defined:
  - Adds output port `carry`, 1 bit, placed after y.
  - carry is registered alongside y and equals bit W of the (W+1)-bit sum a+b.
  - carry updates only on start edges, holds otherwise, and resets to 0.
- Undefined: the port does not exist and the adder computes only W bits. y and valid behaviour are identical in both builds.

Decomposition:
- Package design36_pkg:
  - localparam DEFAULT_W = 10.
  - typedef enum logic {IDLE, DONE} design36_state_t.
- One natural sub-module, design36_adder:
  - Purely combinational.
  - Inputs a, b; outputs sum[W-1:0] and carry.
- The top holds the FSM and the output registers. design36_adder's carry output is left unconnected when DESIGN36_CARRY_OUT_EN is undefined.

Test Plan:
- Reset: hold rst=1 for 3 edges with start=1, a=5, b=7 -> valid=0 and y=0 on every edge; no valid after rst drops unless a new start arrives.
- Basic sum (W=10): a=3, b=5, start for one cycle -> next cycle valid=1, y=8; the following cycle valid=0 and y still 8.
- Wrap-around: a=1023, b=1 -> y=0, valid=1 one cycle later; carry=1 if DESIGN36_CARRY_OUT_EN is defined.
- Back-to-back: start on two consecutive edges with (10,20) then (100,200) -> valid high for 2 cycles, y=30 then y=300, then valid=0.
- Reset mid-operation: start with a=40, b=2, then rst=1 on the next edge -> valid=0 and y=0 at that edge; no stale pulse afterwards.
- Random sweep: 10 random start pulses spaced 3 cycles apart -> every valid coincides with y == (a+b) mod 1024 from the preceding start, and valid is never high without a start on the prior edge.
